// File: rtl/mac_window_seq.sv
// ---------------------------------------------------------------------------
// mac_window_seq
//
// Purpose:
//   Producer/consumer controller for the dual-multiplier add/sub unit in the
//   CNN datapath. Operand beats arrive over a valid/ready stream and are
//   registered into the multiplier's a0/a1/b0/b1/addsub inputs. The
//   multiplier's result p is collected MULT_LAT ce-edges later and summed
//   into a signed accumulator. After BEATS products, the sum is rounded
//   (half up), arithmetically shifted right by SHIFT, saturated to OUT_W
//   bits and offered downstream over a second valid/ready stream.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid / s_ready        operand beat handshake
//   s_a0, s_a1, s_b0, s_b1   beat operands (signed, DW bits)
//   s_sub                    0: a0*b0 + a1*b1, 1: a0*b0 - a1*b1
//   mul_ce                   multiplier clock enable
//   mul_a0 .. mul_b1         registered operands to the multiplier
//   mul_addsub               registered add/sub select to the multiplier
//   mul_p                    multiplier result (signed, PW bits)
//   m_valid / m_ready        window result handshake
//   m_data                   rounded, shifted, saturated window result
//   m_ovf                    m_data was clipped by saturation
//
// Build option:
//   MAC_WINDOW_RELU_EN  when defined, a negative rounded result is forced to
//                       zero before saturation, so m_ovf only flags positive
//                       clipping.
// ---------------------------------------------------------------------------
module mac_window_seq #(
    parameter int DW       = 16,
    parameter int PW       = 33,
    parameter int MULT_LAT = 3,
    parameter int BEATS    = 5,
    parameter int ACC_W    = 40,
    parameter int SHIFT    = 8,
    parameter int OUT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DW-1:0]       s_a0,
    input  logic [DW-1:0]       s_a1,
    input  logic [DW-1:0]       s_b0,
    input  logic [DW-1:0]       s_b1,
    input  logic                s_sub,

    output logic                mul_ce,
    output logic [DW-1:0]       mul_a0,
    output logic [DW-1:0]       mul_a1,
    output logic [DW-1:0]       mul_b0,
    output logic [DW-1:0]       mul_b1,
    output logic                mul_addsub,
    input  logic [PW-1:0]       mul_p,

    output logic                m_valid,
    input  logic                m_ready,
    output logic [OUT_W-1:0]    m_data,
    output logic                m_ovf
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Rounding constant 2^(SHIFT-1) and the signed output range, all held at
    // one bit wider than the accumulator so the rounding add cannot wrap.
    localparam logic signed [ACC_W:0] HALF    = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic                       stall;
    logic                       ce;
    logic                       accept;
    logic [CNT_W-1:0]           beat_cnt;

    // Tag pipeline: one entry per ce edge. When a valid tag reaches the top
    // stage, mul_p holds the product of that beat.
    logic [MULT_LAT:0]          tag_valid;
    logic [MULT_LAT:0]          tag_last;

    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    p_ext;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W:0]      rnd_sum;
    logic signed [ACC_W:0]      rnd_val;
    logic [OUT_W-1:0]           sat_data;
    logic                       sat_ovf;

    // A result waiting on a busy consumer freezes the whole pipe, including
    // the multiplier, so no product can be lost while the output is held.
    assign stall   = m_valid && !m_ready;
    assign ce      = !stall && !rst;
    assign mul_ce  = ce;
    assign s_ready = ce;
    assign accept  = s_valid && s_ready;

    // Accumulate path and output formatting for a possible window end.
    always_comb begin
        p_ext    = ACC_W'($signed(mul_p));
        acc_next = acc + p_ext;
        rnd_sum  = (ACC_W + 1)'(acc_next) + HALF;
        rnd_val  = rnd_sum >>> SHIFT;
`ifdef MAC_WINDOW_RELU_EN
        if (rnd_val[ACC_W]) begin
            rnd_val = '0;
        end
`endif
        sat_data = rnd_val[OUT_W-1:0];
        sat_ovf  = 1'b0;
        if (rnd_val > OUT_MAX) begin
            sat_data = OUT_MAX[OUT_W-1:0];
            sat_ovf  = 1'b1;
        end else if (rnd_val < OUT_MIN) begin
            sat_data = OUT_MIN[OUT_W-1:0];
            sat_ovf  = 1'b1;
        end
    end

    // Operand registers, beat counter and tag pipeline. Everything advances
    // only on ce edges; mul_* keep their old value when no beat is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a0     <= '0;
            mul_a1     <= '0;
            mul_b0     <= '0;
            mul_b1     <= '0;
            mul_addsub <= 1'b0;
            beat_cnt   <= '0;
            tag_valid  <= '0;
            tag_last   <= '0;
        end else if (ce) begin
            if (accept) begin
                mul_a0     <= s_a0;
                mul_a1     <= s_a1;
                mul_b0     <= s_b0;
                mul_b1     <= s_b1;
                mul_addsub <= s_sub;
                beat_cnt   <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            end
            tag_valid[0] <= accept;
            tag_last[0]  <= accept && (beat_cnt == LAST_BEAT);
            for (int i = 1; i <= MULT_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
        end
    end

    // Accumulator and output register. A window ending on the same edge the
    // previous result is taken reloads m_data with m_valid kept high, so
    // back-to-back windows leave no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ovf   <= 1'b0;
        end else if (ce) begin
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (tag_valid[MULT_LAT]) begin
                if (tag_last[MULT_LAT]) begin
                    acc     <= '0;
                    m_data  <= sat_data;
                    m_ovf   <= sat_ovf;
                    m_valid <= 1'b1;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_window_seq.sv
// ---------------------------------------------------------------------------
// tb_mac_window_seq
//
// Directed bench for mac_window_seq. A behavioural three-stage multiplier
// (ce-gated) sits on the mul_* ports. Window results are collected at each
// output handshake and compared with hand-computed values.
// ---------------------------------------------------------------------------
module tb_mac_window_seq;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic               s_ready;
    logic [15:0]        s_a0, s_a1, s_b0, s_b1;
    logic               s_sub;
    logic               mul_ce;
    logic [15:0]        mul_a0, mul_a1, mul_b0, mul_b1;
    logic               mul_addsub;
    logic [32:0]        mul_p;
    logic               m_valid;
    logic               m_ready;
    logic [15:0]        m_data;
    logic               m_ovf;

    int                 tests  = 0;
    int                 failed = 0;
    int unsigned        cyc    = 0;
    int unsigned        last_accept = 0;

    logic signed [15:0] res_data[$];
    logic               res_ovf[$];
    int unsigned        res_cyc[$];

`ifdef MAC_WINDOW_RELU_EN
    localparam int EXP_SUB = 0;
`else
    localparam int EXP_SUB = -5;
`endif

    mac_window_seq dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_a0       (s_a0),
        .s_a1       (s_a1),
        .s_b0       (s_b0),
        .s_b1       (s_b1),
        .s_sub      (s_sub),
        .mul_ce     (mul_ce),
        .mul_a0     (mul_a0),
        .mul_a1     (mul_a1),
        .mul_b0     (mul_b0),
        .mul_b1     (mul_b1),
        .mul_addsub (mul_addsub),
        .mul_p      (mul_p),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_ovf      (m_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: product visible three ce edges after the
    // operands are registered.
    logic signed [15:0] ma0, ma1, mb0, mb1;
    logic signed [32:0] p1 = '0, p2 = '0, p3 = '0;
    assign ma0   = mul_a0;
    assign ma1   = mul_a1;
    assign mb0   = mul_b0;
    assign mb1   = mul_b1;
    assign mul_p = p3;

    always @(posedge clk) begin
        if (mul_ce) begin
            p1 <= mul_addsub ? (ma0 * mb0 - ma1 * mb1) : (ma0 * mb0 + ma1 * mb1);
            p2 <= p1;
            p3 <= p2;
        end
    end

    // Record every output handshake, sampled between clock edges.
    always @(negedge clk) begin
        #1;
        if (m_valid && m_ready) begin
            res_data.push_back(m_data);
            res_ovf.push_back(m_ovf);
            res_cyc.push_back(cyc);
        end
    end

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer one beat and hold it until accepted; returns on the negedge
    // right after the accept edge so calls chain into continuous beats.
    task automatic applyStimulus(input logic [15:0] a0, input logic [15:0] a1,
                                 input logic [15:0] b0, input logic [15:0] b1,
                                 input logic sub);
        int w;
        s_valid = 1'b1;
        s_a0 = a0;
        s_a1 = a1;
        s_b0 = b0;
        s_b1 = b1;
        s_sub = sub;
        w = 0;
        while (!s_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) begin
            checkOutput("beat_accept_timeout", 0, 1);
        end
        @(negedge clk);
        last_accept = cyc;
        s_valid = 1'b0;
    endtask

    task automatic waitResults(input int n);
        int w;
        w = 0;
        while (res_data.size() < n && w < 100) begin
            @(negedge clk);
            w++;
        end
        #2;
        checkOutput("result_count_wait", res_data.size(), n);
    endtask

    task automatic checkResult(input string tag, input int idx,
                               input longint exp_data, input longint exp_ovf);
        if (res_data.size() > idx) begin
            checkOutput({tag, "_data"}, res_data[idx], exp_data);
            checkOutput({tag, "_ovf"}, res_ovf[idx], exp_ovf);
        end else begin
            checkOutput({tag, "_missing"}, res_data.size(), idx + 1);
        end
    endtask

    task automatic clearResults();
        res_data.delete();
        res_ovf.delete();
        res_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        s_valid = 1'b0;
        s_a0 = '0; s_a1 = '0; s_b0 = '0; s_b1 = '0;
        s_sub = 1'b0;
        m_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_s_ready", s_ready, 0);
        checkOutput("rst_mul_ce", mul_ce, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_m_ovf", m_ovf, 0);
        checkOutput("rst_mul_a0", mul_a0, 0);
        checkOutput("rst_mul_addsub", mul_addsub, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_s_ready", s_ready, 1);
        checkOutput("idle_mul_ce", mul_ce, 1);

        // Window of 5 x 256*256: 327680 -> 1280, rise 4 edges after last accept
        clearResults();
        repeat (5) applyStimulus(16'd256, 16'd0, 16'd256, 16'd0, 1'b0);
        checkOutput("basic_reg_a0", mul_a0, 256);
        waitResults(1);
        checkResult("basic", 0, 1280, 0);
        if (res_cyc.size() > 0) begin
            checkOutput("basic_latency", longint'(res_cyc[0]) - longint'(last_accept), 4);
        end
        repeat (5) @(negedge clk);

        // Positive saturation: acc = 10736762890
        clearResults();
        repeat (5) applyStimulus(16'd32767, 16'd32767, 16'd32767, 16'd32767, 1'b0);
        waitResults(1);
        checkResult("sat", 0, 32767, 1);
        repeat (5) @(negedge clk);

        // Subtract mode: acc = -1280 -> -5 (0 with ReLU)
        clearResults();
        repeat (5) applyStimulus(16'd0, 16'd16, 16'd0, 16'd16, 1'b1);
        checkOutput("sub_reg_addsub", mul_addsub, 1);
        waitResults(1);
        checkResult("sub", 0, EXP_SUB, 0);
        repeat (5) @(negedge clk);

        // Two back-to-back windows with a 6-cycle downstream hold
        clearResults();
        m_ready = 1'b0;
        fork
            begin
                repeat (10) applyStimulus(16'd256, 16'd0, 16'd256, 16'd0, 1'b0);
            end
            begin
                int w;
                w = 0;
                while (!m_valid && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                checkOutput("hold_first_valid", m_valid, 1);
                for (int i = 0; i < 6; i++) begin
                    checkOutput("hold_s_ready", s_ready, 0);
                    checkOutput("hold_mul_ce", mul_ce, 0);
                    checkOutput("hold_m_data", $signed(m_data), 1280);
                    @(negedge clk);
                end
                m_ready = 1'b1;
            end
        join
        waitResults(2);
        checkResult("b2b_first", 0, 1280, 0);
        checkResult("b2b_second", 1, 1280, 0);
        repeat (20) @(negedge clk);
        checkOutput("b2b_no_dup", res_data.size(), 2);

        // Reset in the middle of a window discards the partial sum
        clearResults();
        repeat (2) applyStimulus(16'd32767, 16'd32767, 16'd32767, 16'd32767, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) applyStimulus(16'd256, 16'd0, 16'd256, 16'd0, 1'b0);
        waitResults(1);
        checkResult("midrst", 0, 1280, 0);
        repeat (20) @(negedge clk);
        checkOutput("midrst_count", res_data.size(), 1);

        // Continuous stream with m_ready tied high: one result every 5 cycles
        clearResults();
        repeat (15) applyStimulus(16'd256, 16'd0, 16'd256, 16'd0, 1'b0);
        waitResults(3);
        for (int i = 0; i < 3; i++) begin
            checkResult("stream", i, 1280, 0);
        end
        for (int i = 1; i < res_cyc.size(); i++) begin
            checkOutput("stream_spacing", longint'(res_cyc[i]) - longint'(res_cyc[i-1]), 5);
        end
        repeat (20) @(negedge clk);
        checkOutput("stream_count", res_data.size(), 3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
